// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two-requester front end for one shared branch comparator.
//
// Requesters 0 and 1 each present operands and a branch funct3. In the idle state one
// request is granted. It goes to the only valid requester, or to the priority holder
// when both are valid. The granted operands are driven combinationally to the external
// comparator. Its combinational result (cmp_br_en) is captured in the same cycle. The
// captured result is held for the owning requester until that requester consumes it.
// Priority then passes to the other requester, which gives strict alternation under
// contention.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   reqN_valid / reqN_ready  compare request handshake (N = 0, 1)
//   reqN_rs1, reqN_rs2       operands, sampled only in the accept cycle
//   reqN_op                  branch funct3 (beq/bne/blt/bge/bltu/bgeu)
//   cmp_rs1, cmp_rs2, cmp_op operands and op to the shared comparator (zero / beq when unused)
//   cmp_mux                  comparator mux select, always rs2_out
//   cmp_br_en                comparator result, combinational from cmp_*
//   respN_valid / respN_ready result handshake
//   respN_br_en              registered compare result
module cmp_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_rs1,
  input  logic [WIDTH-1:0] req0_rs2,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_rs1,
  input  logic [WIDTH-1:0] req1_rs2,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] cmp_rs1,
  output logic [WIDTH-1:0] cmp_rs2,
  output logic [2:0]       cmp_op,
  output logic             cmp_mux,
  input  logic             cmp_br_en,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp0_br_en,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic             resp1_br_en
);

  localparam logic [2:0] OpBeq        = 3'b000;
  localparam logic       CmpMuxRs2Out = 1'b0;

  typedef enum logic {StIdle, StResp} state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;      // requester that wins when both are valid
  logic   owner_q, owner_d;    // requester that owns the held result
  logic   result_q, result_d;

  logic any_valid;
  logic grant;
  logic accept;
  logic is_branch;
  logic holding;
  logic owner_ready;

  // Grant and accept. Only a valid requester can be granted, so the ready output
  // doubles as the accept strobe.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    // Both valid: the priority holder wins. Only one valid: that one wins. With
    // neither valid the grant is unused.
    grant     = (req0_valid & req1_valid) ? prio_q : req1_valid;
    accept    = ~rst & (state_q == StIdle) & any_valid;

    req0_ready = accept & ~grant;
    req1_ready = accept & grant;
  end

  // Comparator drive. It is non-zero only in an accept cycle.
  always_comb begin
    cmp_rs1 = '0;
    cmp_rs2 = '0;
    cmp_op  = OpBeq;
    cmp_mux = CmpMuxRs2Out;
    if (accept) begin
      cmp_rs1 = grant ? req1_rs1 : req0_rs1;
      cmp_rs2 = grant ? req1_rs2 : req0_rs2;
      cmp_op  = grant ? req1_op  : req0_op;
    end
  end

  // funct3 010 and 011 are not branches. Force their result low so that the shared
  // comparator's output for those codes is ignored.
  assign is_branch = (cmp_op[2:1] != 2'b01);

  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StResp;
          owner_d  = grant;
          prio_d   = ~grant;
          result_d = cmp_br_en & is_branch;
        end
      end
      StResp: begin
        // The response is consumed here. This state raises no ready, so no accept
        // can overlap it.
        if (owner_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response outputs. They are gated by rst so that a reset in the hold state
  // hides the result at once.
  always_comb begin
    holding     = ~rst & (state_q == StResp);
    resp0_valid = holding & ~owner_q;
    resp1_valid = holding & owner_q;
    resp0_br_en = holding & ~owner_q & result_q;
    resp1_br_en = holding & owner_q & result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter. A transaction-level model (pending flag, owner, result,
// priority) predicts every output on every cycle. The comparator is modelled here as
// well. For the non-branch codes 010/011 it deliberately returns 1, so that the
// arbiter's masking of those codes is observable.
module tb_cmp_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         v[2];
  logic [W-1:0] a[2];
  logic [W-1:0] b[2];
  logic [2:0]   op[2];
  logic         rr[2];

  logic         rdy0, rdy1, rv0, rv1, rb0, rb1, cmux, cbr;
  logic [W-1:0] c1, c2;
  logic [2:0]   cop;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(rdy0), .req0_rs1(a[0]), .req0_rs2(b[0]), .req0_op(op[0]),
    .req1_valid(v[1]), .req1_ready(rdy1), .req1_rs1(a[1]), .req1_rs2(b[1]), .req1_op(op[1]),
    .cmp_rs1(c1), .cmp_rs2(c2), .cmp_op(cop), .cmp_mux(cmux), .cmp_br_en(cbr),
    .resp0_valid(rv0), .resp0_ready(rr[0]), .resp0_br_en(rb0),
    .resp1_valid(rv1), .resp1_ready(rr[1]), .resp1_br_en(rb1)
  );

  // Branch semantics. junk=1 models the raw comparator, which gives 1 for 010/011.
  function automatic bit branch(input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [2:0] f, input bit junk);
    case (f)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return $signed(x) < $signed(y);
      3'b101:  return $signed(x) >= $signed(y);
      3'b110:  return x < y;
      3'b111:  return x >= y;
      default: return junk;
    endcase
  endfunction

  assign cbr = branch(c1, c2, cop, 1'b1);

  // Reference model state.
  bit pend, res;
  int own, prio;
  int checks = 0, errors = 0;
  int last_g;
  bit s_rdy0, s_rdy1, s_rv0, s_rv1, s_rb0, s_rb1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at a negedge with the inputs already set. Checks this cycle, advances the
  // model at the posedge, and returns at the next negedge.
  task automatic cycle();
    int g;
    bit ev0, ev1;
    #1;
    g = -1;
    if (!rst && !pend) begin
      if (v[0] && v[1]) g = prio;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
    end
    last_g = g;
    ev0 = !rst && pend && own == 0;
    ev1 = !rst && pend && own == 1;
    chk("req0_ready", rdy0, g == 0);
    chk("req1_ready", rdy1, g == 1);
    chk("cmp_rs1", c1, (g >= 0) ? a[g] : '0);
    chk("cmp_rs2", c2, (g >= 0) ? b[g] : '0);
    chk("cmp_op", cop, (g >= 0) ? op[g] : 3'b000);
    chk("cmp_mux", cmux, 1'b0);
    chk("resp0_valid", rv0, ev0);
    chk("resp1_valid", rv1, ev1);
    chk("resp0_br_en", rb0, ev0 && res);
    chk("resp1_br_en", rb1, ev1 && res);
    {s_rdy0, s_rdy1, s_rv0, s_rv1, s_rb0, s_rb1} = {rdy0, rdy1, rv0, rv1, rb0, rb1};
    @(posedge clk);
    if (rst) begin
      pend = 0; prio = 0; own = 0; res = 0;
    end else if (pend) begin
      if (rr[own]) pend = 0;
    end else if (g >= 0) begin
      pend = 1; own = g; prio = 1 - g;
      res  = branch(a[g], b[g], op[g], 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; a[i] = '0; b[i] = '0; op[i] = 3'b000; rr[i] = 1;
    end
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  int gseq[$];
  int gcyc[$];

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    reset_dut();
    chk("reset_ready0", s_rdy0, 0);
    chk("reset_valid0", s_rv0, 0);

    // Scenario 1: beq 5 vs 5 from requester 0 alone.
    v[0] = 1; a[0] = 5; b[0] = 5; op[0] = 3'b000;
    cycle();
    chk("s1_ready0", s_rdy0, 1);
    v[0] = 0;
    cycle();
    chk("s1_resp0_valid", s_rv0, 1);
    chk("s1_resp0_br_en", s_rb0, 1);
    cycle();

    // Scenario 2: both valid after reset. req0 blt is signed, req1 bltu is unsigned.
    reset_dut();
    v[0] = 1; a[0] = 32'hFFFF_FFFF; b[0] = 1; op[0] = 3'b100;
    v[1] = 1; a[1] = 32'hFFFF_FFFF; b[1] = 1; op[1] = 3'b110;
    cycle();
    chk("s2_first_grant0", s_rdy0, 1);
    v[0] = 0;
    cycle();
    chk("s2_resp0_br_en", s_rb0, 1);
    cycle();
    chk("s2_second_grant1", s_rdy1, 1);
    v[1] = 0;
    cycle();
    chk("s2_resp1_valid", s_rv1, 1);
    chk("s2_resp1_br_en", s_rb1, 0);

    // Scenario 3: bne 7 vs 7, response stalled for 3 cycles while req1 waits.
    idle_inputs();
    v[0] = 1; a[0] = 7; b[0] = 7; op[0] = 3'b001;
    cycle();
    rr[0] = 0; v[1] = 1; a[1] = 3; b[1] = 3;
    for (int i = 0; i < 3; i++) begin
      a[0] = $urandom; op[0] = 3'b000;  // must not alter the held result
      cycle();
      chk("s3_stall_valid", s_rv0, 1);
      chk("s3_stall_br_en", s_rb0, 0);
      chk("s3_stall_ready", {s_rdy0, s_rdy1}, 2'b00);
    end
    rr[0] = 1; v[0] = 0; v[1] = 0;
    cycle();
    cycle();

    // Scenario 4: non-branch op 010 from req1. The raw comparator says 1; the result must be 0.
    v[1] = 1; a[1] = 0; b[1] = 0; op[1] = 3'b010;
    cycle();
    v[1] = 0;
    cycle();
    chk("s4_resp1_valid", s_rv1, 1);
    chk("s4_resp1_br_en", s_rb1, 0);

    // Scenario 5: reset while holding a req0 result, which leaves prio=1 before the reset.
    idle_inputs();
    reset_dut();
    v[0] = 1; a[0] = 1; b[0] = 1;
    cycle();
    v[0] = 0; rr[0] = 0;
    rst = 1;
    cycle();
    rst = 0; rr[0] = 1;
    v[0] = 1; v[1] = 1;
    cycle();
    chk("s5_valid_after_rst", {s_rv0, s_rv1}, 2'b00);
    chk("s5_grant0", s_rdy0, 1);
    v[0] = 0; v[1] = 0;
    cycle();
    cycle();

    // Scenario 6: continuous contention gives alternation, one accept every 2 cycles.
    reset_dut();
    v[0] = 1; v[1] = 1; op[0] = 3'b101; op[1] = 3'b111;
    for (int c = 0; c < 16; c++) begin
      a[0] = $urandom; b[0] = $urandom; a[1] = $urandom; b[1] = $urandom;
      cycle();
      if (s_rdy0 || s_rdy1) begin
        gseq.push_back(s_rdy1 ? 1 : 0);
        gcyc.push_back(c);
      end
    end
    chk("s6_accepts", gseq.size(), 8);
    foreach (gseq[i]) begin
      chk("s6_order", gseq[i], i % 2);
      chk("s6_spacing", gcyc[i], 2 * i);
    end

    // Random traffic.
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        v[i]  = $urandom_range(0, 2) != 0;
        rr[i] = $urandom_range(0, 2) != 0;
        op[i] = 3'($urandom);
        a[i]  = $urandom;
        b[i]  = ($urandom_range(0, 3) == 0) ? a[i] :
                ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
